mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port instruction/data SRAM between the core instruction fetch port and the core data port. It accepts OBI-style req/gnt/rvalid transactions from both core ports and grants at most one per cycle to the SRAM. It routes the 1-cycle-latency SRAM read data back to the owning port. It sits between the core wrapper and the SRAM macro in the core part, and freezes all grants while the configuration port owns the memory (`conf_sel`).

## Interface

Parameters:
- `ADDR_W`, default 14: SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- `MAX_WAIT`, default 4: number of consecutive cycles an instruction request may lose to data before it is forced to win. Range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `conf_sel` in 1: the configuration port owns the SRAM; no new grants are issued.
- `instr_req_i` in 1: instruction fetch request.
- `instr_addr_i` in 32: fetch byte address.
- `instr_gnt_o` out 1: fetch accepted this cycle (combinational).
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out 32: fetch response data.
- `data_req_i` in 1: data request, already qualified to SRAM space by the top.
- `data_addr_i` in 32: data byte address.
- `data_we_i` in 1: 1 = write.
- `data_be_i` in 4: byte enables.
- `data_wdata_i` in 32: write data.
- `data_gnt_o` out 1: data request accepted this cycle (combinational).
- `data_rvalid_o` out 1: data response valid (reads and writes).
- `data_rdata_o` out 32: data response data.
- `mem_en_o` out 1: SRAM access this cycle.
- `mem_we_o` out 1: SRAM write.
- `mem_be_o` out 4: SRAM byte enables.
- `mem_addr_o` out ADDR_W: SRAM word address.
- `mem_wdata_o` out 32: SRAM write data.
- `mem_rdata_i` in 32: SRAM read data, valid 1 cycle after `mem_en_o`.

## Operation

- Arbitration, evaluated combinationally each cycle:
  - No grant while `conf_sel`=1 or `resetn`=0.
  - Otherwise, data wins if `data_req_i`=1 and `wait_cnt` < MAX_WAIT.
  - Otherwise, instr wins if `instr_req_i`=1.
  - Otherwise, data wins if `data_req_i`=1.
- Exactly one of `instr_gnt_o`/`data_gnt_o` is high in any cycle, or neither.
- Memory drive:
  - `mem_en_o` = OR of the two grants.
  - On an instr grant: `mem_we_o`=0, `mem_be_o`=4'hF.
  - On a data grant: `mem_we_o`=`data_we_i` and `mem_be_o`=`data_be_i`.
  - `mem_addr_o` = winner address[ADDR_W+1:2]. `mem_wdata_o` = `data_wdata_i`.
  - With no grant, all `mem_*` outputs are 0.
- Starvation counter `wait_cnt` (4 bits):
  - Clears to 0 when `instr_req_i`=0 or `instr_gnt_o`=1.
  - Increments, saturating at MAX_WAIT, when `instr_req_i`=1, `instr_gnt_o`=0 and `conf_sel`=0.
  - Holds while `conf_sel`=1.
- Response routing:
  - Registers `resp_instr` and `resp_data` are set to the respective grant each cycle.
  - `instr_rvalid_o` = `resp_instr`; `data_rvalid_o` = `resp_data`.
  - `*_rdata_o` = `mem_rdata_i` when the corresponding rvalid is 1, else 32'h0.
  - Write responses return rvalid with `mem_rdata_i` passed through; the core ignores this data.
- `conf_sel` asserted mid-stream: a response for a grant issued in the previous cycle is still delivered.
- Requests held during `conf_sel` are granted after it deasserts.

## Timing

- Reset values: `resp_instr`=`resp_data`=0 and `wait_cnt`=0. Every output is 0 while `resetn`=0.
- Grant latency: 0 cycles (same-cycle gnt).
- Response latency: `rvalid` exactly 1 cycle after `gnt`.
- Throughput: one transaction per cycle, back-to-back, with a different owner allowed each cycle.
- Handshake: a request is taken only in a cycle where req=1 and gnt=1. The requester holds address, we, be and wdata stable until gnt.
- Reset mid-operation: a pending response is dropped (no rvalid after reset release).
- Simultaneous requests with `wait_cnt` = MAX_WAIT: instr wins and the counter clears in the same edge.

## Test plan

- Single fetch: `instr_req_i`=1, addr 0x180 at cycle 0. Expect `instr_gnt_o`=1 and `mem_addr_o`=0x60 at cycle 0; `instr_rvalid_o`=1 with data from `mem_rdata_i` at cycle 1.
- Data write: addr 0x1004, be 4'b0011, wdata 0xA5A5_5A5A. Expect `mem_we_o`=1, `mem_be_o`=3, `mem_addr_o`=0x401; `data_rvalid_o`=1 next cycle; no instr rvalid.
- Contention, MAX_WAIT=4, both reqs held high for 15 cycles. Expect the grant pattern D,D,D,D,I repeated three times; rvalids follow each grant by 1 cycle with the matching owner.
- `conf_sel` pulse high for 3 cycles while both request. Expect zero grants and `mem_en_o`=0; `wait_cnt` frozen. On release, arbitration resumes from the frozen count.
- `conf_sel` rises the cycle after a data grant. Expect `data_rvalid_o`=1 in the first conf cycle.
- Assert `resetn`=0 one cycle after an instr grant. Expect `instr_rvalid_o`=0 immediately and no response after release; the first post-reset request is granted with `wait_cnt`=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port SRAM between the instruction fetch and data ports.
// Data has priority, bounded by a starvation counter that forces instruction fetches through.
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              conf_sel,
    // Handshake (both ports): a request is taken in a cycle where req=1 and gnt=1; the
    // requester holds its address/controls stable until then, and rvalid follows 1 cycle later.
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    input  logic              data_req_i,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       resp_instr;
    logic       resp_data;

    // Only the word-address bits reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0],
                                data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};

    // Grants are gated by resetn as well so every output is quiet during reset.
    always_comb begin
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (resetn && !conf_sel) begin
            if (data_req_i && (wait_cnt < WAIT_LIMIT)) begin
                data_gnt_o = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt_o = 1'b1;
            end else if (data_req_i) begin
                data_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = instr_gnt_o | data_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (instr_gnt_o) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i[ADDR_W+1:2];
            mem_wdata_o = data_wdata_i;
        end else if (data_gnt_o) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i[ADDR_W+1:2];
            mem_wdata_o = data_wdata_i;
        end
    end

    // The counter freezes under conf_sel so arbitration resumes where it left off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt   <= 4'd0;
            resp_instr <= 1'b0;
            resp_data  <= 1'b0;
        end else begin
            resp_instr <= instr_gnt_o;
            resp_data  <= data_gnt_o;
            if (!instr_req_i || instr_gnt_o) begin
                wait_cnt <= 4'd0;
            end else if (!conf_sel && (wait_cnt < WAIT_LIMIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign instr_rvalid_o = resp_instr;
    assign data_rvalid_o  = resp_data;
    assign instr_rdata_o  = resp_instr ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = resp_data  ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle grant/memory checks plus a response
// scoreboard that a separate monitor drains one entry per cycle.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              conf_sel;
    logic              instr_req_i;
    logic [31:0]       instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_rdata_o;
    logic              data_req_i;
    logic [31:0]       data_addr_i;
    logic              data_we_i;
    logic [3:0]        data_be_i;
    logic [31:0]       data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [31:0]       data_rdata_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [65:0] exp_q[$];
    logic [65:0] mon_exp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .conf_sel      (conf_sel),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    // Address-tagged word so each response shows which address was accessed.
    function automatic logic [31:0] sram_word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    always @(posedge clk) mem_rdata_i <= mem_en_o ? sram_word(mem_addr_o) : 32'hDEAD_BEEF;

    function automatic logic [65:0] resp(input logic ri, input logic rd, input logic [13:0] a);
        return {ri, rd, (ri ? sram_word(a) : 32'h0), (rd ? sram_word(a) : 32'h0)};
    endfunction

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        conf_sel     = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
    endtask

    // Check this cycle's grant and SRAM drive, and queue next cycle's expected response.
    task automatic tick(input string name, input logic eig, input logic edg,
                        input logic [13:0] eaddr, input logic ewe, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic live);
        @(negedge clk);
        cmp({name, "_gnt"}, 128'({instr_gnt_o, data_gnt_o}), 128'({eig, edg}));
        cmp({name, "_mem"},
            128'({mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
            128'({eig | edg, ewe, ebe, eaddr, ewd}));
        if (live) exp_q.push_back(resp(eig, edg, eaddr));
        else      exp_q.push_back(resp(1'b0, 1'b0, eaddr));
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected response entry per cycle once the driver has started.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                cmp("resp", 128'({instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o}),
                    128'(mon_exp));
            end else begin
                cmp("idle_rvalid", 128'({instr_rvalid_o, data_rvalid_o}), 128'(0));
            end
        end
    end

    initial begin
        resetn       = 1'b1;
        conf_sel     = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h180;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h1004;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_wdata_i = 32'h1234_5678;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset_outputs",
            128'({instr_gnt_o, data_gnt_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                  instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o}),
            128'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        set_idle();
        tick("idle0", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);

        // Single fetch.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h180;
        tick("fetch", 1'b1, 1'b0, 14'h060, 1'b0, 4'hF, 32'h0, 1'b1);
        set_idle();
        tick("idle1", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);

        // Data write.
        data_req_i   = 1'b1;
        data_addr_i  = 32'h1004;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_wdata_i = 32'hA5A5_5A5A;
        tick("dwrite", 1'b0, 1'b1, 14'h401, 1'b1, 4'h3, 32'hA5A5_5A5A, 1'b1);
        set_idle();
        tick("idle2", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);

        // Contention: D,D,D,D,I three times.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h200;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 4) tick("cont_i", 1'b1, 1'b0, 14'h080, 1'b0, 4'hF, 32'h0, 1'b1);
            else            tick("cont_d", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        end

        // Two data wins, 3-cycle conf freeze, then two more data wins before instr.
        tick("conf_pre", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        tick("conf_pre", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        conf_sel = 1'b1;
        for (int i = 0; i < 3; i++) tick("conf_hold", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        conf_sel = 1'b0;
        tick("conf_post", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        tick("conf_post", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        tick("conf_post_i", 1'b1, 1'b0, 14'h080, 1'b0, 4'hF, 32'h0, 1'b1);

        // conf_sel rises right after a data grant; that response still arrives.
        set_idle();
        tick("idle3", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        data_req_i  = 1'b1;
        data_addr_i = 32'h40;
        data_be_i   = 4'hF;
        tick("pre_conf_d", 1'b0, 1'b1, 14'h010, 1'b0, 4'hF, 32'h0, 1'b1);
        data_addr_i = 32'h44;
        conf_sel    = 1'b1;
        tick("conf_block", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        conf_sel = 1'b0;
        tick("conf_release", 1'b0, 1'b1, 14'h011, 1'b0, 4'hF, 32'h0, 1'b1);

        // Reset one cycle after an instr grant drops its response.
        set_idle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h84;
        tick("rst_grant", 1'b1, 1'b0, 14'h021, 1'b0, 4'hF, 32'h0, 1'b0);
        resetn       = 1'b0;
        instr_addr_i = 32'h200;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        data_be_i    = 4'hF;
        tick("rst_hold", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick("rst_hold", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick("post_rst_d", 1'b0, 1'b1, 14'h0C0, 1'b0, 4'hF, 32'h0, 1'b1);
        tick("post_rst_i", 1'b1, 1'b0, 14'h080, 1'b0, 4'hF, 32'h0, 1'b1);

        set_idle();
        tick("idle4", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        tick("idle5", 1'b0, 1'b0, 14'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
